// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU use shift-add on operand magnitudes and DIV/DIVU use restoring
//   division on magnitudes. Each produces one result bit per cycle.
//   Sign correction and the HI/LO write happen in a final FIN cycle.
//   MTHI/MTLO write HI or LO directly on the accepting edge.
//
//   Optional feature macro: MDU_DIV_EN
//     defined   - divider datapath is built; DIV/DIVU run as iterative ops
//     undefined - no divider logic; DIV/DIVU are no-ops and dz is tied low
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset, clears all state
//   start  in   operation request, accepted only while busy=0
//   op     in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   a      in   multiplicand / dividend / MTHI-MTLO source
//   b      in   multiplier / divisor
//   hi     out  product upper half or remainder
//   lo     out  product lower half or quotient
//   busy   out  iterative operation in progress
//   done   out  one-cycle pulse when hi/lo hold a new result
//   dz     out  divide-by-zero flag, meaningful only while done=1
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int            CW         = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  // Multiplicand magnitude for multiplies, divisor magnitude for divides
  logic [WIDTH-1:0]   r_opnd;
  // Working register: {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_p;
  logic               r_aNeg;
  logic               r_bNeg;
  logic               r_done;

  logic               w_accept;
  logic               w_signedOp;
  logic               w_aNeg;
  logic               w_bNeg;
  logic               w_launchMul;
  logic               w_launchDiv;
  logic               w_launch;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [WIDTH:0]     w_addSum;
  logic [2*WIDTH-1:0] w_mulStep;
  logic [2*WIDTH-1:0] w_pNext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_resHi;
  logic [WIDTH-1:0]   w_resLo;

  assign busy = (r_state != S_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

  // Request decode. Signed ops (even opcodes) take operand magnitudes so the
  // iteration itself is always unsigned; the signs are kept for FIN.
  assign w_accept    = start && !busy;
  assign w_signedOp  = ~op[0];
  assign w_aNeg      = w_signedOp && a[WIDTH-1];
  assign w_bNeg      = w_signedOp && b[WIDTH-1];
  assign w_aMag      = w_aNeg ? -a : a;
  assign w_bMag      = w_bNeg ? -b : b;
  assign w_launchMul = w_accept && (op[2:1] == 2'b00);
  assign w_launch    = w_launchMul || w_launchDiv;

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole pair right, retiring one multiplier bit.
  assign w_addSum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
  assign w_mulStep = {w_addSum, r_p[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic               r_isDiv;
  logic               r_dz;
  logic [WIDTH-1:0]   r_aRaw;
  logic               w_qBit;
  logic               w_divZero;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_divStep;

  assign w_launchDiv = w_accept && (op[2:1] == 2'b01);
  assign w_divZero   = (r_opnd == '0);
  assign dz          = r_dz;

  // Restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not borrow.
  assign w_trial   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff    = w_trial - {1'b0, r_opnd};
  assign w_qBit    = ~w_diff[WIDTH];
  assign w_divStep = {(w_qBit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                      r_p[WIDTH-2:0], w_qBit};

  // Divide bookkeeping: raw dividend is kept because a zero divisor
  // returns it untouched in HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_isDiv <= 1'b0;
      r_aRaw  <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_dz <= (r_state == S_FIN) && r_isDiv && w_divZero;
      if (w_launch) begin
        r_isDiv <= w_launchDiv;
        r_aRaw  <= a;
      end
    end
  end
`else
  assign w_launchDiv = 1'b0;
  assign dz          = 1'b0;
`endif

  // Next value of the working register while iterating
  always_comb begin
    w_pNext = w_mulStep;
`ifdef MDU_DIV_EN
    if (r_isDiv) begin
      w_pNext = w_divStep;
    end
`endif
  end

  // FIN result: negate the full product when operand signs differ; for
  // divides the quotient follows sign(a)^sign(b) and the remainder sign(a).
  // Signed MIN/-1 wraps back to MIN naturally through the negation.
  always_comb begin
    w_prod  = (r_aNeg ^ r_bNeg) ? -r_p : r_p;
    w_resHi = w_prod[2*WIDTH-1:WIDTH];
    w_resLo = w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (r_isDiv) begin
      if (w_divZero) begin
        w_resHi = r_aRaw;
        w_resLo = '1;
      end else begin
        w_resLo = (r_aNeg ^ r_bNeg) ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
        w_resHi = r_aNeg ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  // Control FSM and HI/LO. HI/LO only change on FIN or an MTHI/MTLO, so an
  // aborting reset never leaves a partial result behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_p     <= '0;
      r_aNeg  <= 1'b0;
      r_bNeg  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_aNeg  <= w_aNeg;
            r_bNeg  <= w_bNeg;
            r_opnd  <= w_launchDiv ? w_bMag : w_aMag;
            r_p     <= {{WIDTH{1'b0}}, (w_launchDiv ? w_aMag : w_bMag)};
          end else if (w_accept && (op == OP_MTHI)) begin
            r_hi <= a;
          end else if (w_accept && (op == OP_MTLO)) begin
            r_lo <= a;
          end
        end
        S_RUN: begin
          r_p <= w_pNext;
          if (r_count == LAST_COUNT) begin
            r_state <= S_FIN;
            r_count <= '0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_FIN: begin
          r_hi    <= w_resHi;
          r_lo    <= w_resLo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. A 32-bit instance covers the
//   main operations and handshake; an 8-bit instance covers the small-width
//   signed corner case and back-to-back acceptance on the done cycle.
//   Expected results come from a behavioural model using the language's own
//   arithmetic and are queued when an operation is issued, then popped when
//   the unit reports done. Divide expectations depend on MDU_DIV_EN.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dz;

  logic        s8Start;
  logic [2:0]  s8Op;
  logic [7:0]  s8A;
  logic [7:0]  s8B;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        busy8;
  logic        done8;
  logic        dz8;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
  } exp8_t;

  exp_t  sbQ[$];
  exp8_t sb8Q[$];

  mult_div_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dz(dz)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8Start), .op(s8Op), .a(s8A), .b(s8B),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .dz(dz8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour using native 64-bit arithmetic
  function automatic exp_t model(input logic [2:0] mOp, input logic [31:0] mA,
                                 input logic [31:0] mB);
    exp_t        e;
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    e.hi = '0;
    e.lo = '0;
    e.dz = 1'b0;
    sa = longint'($signed(mA));
    sb = longint'($signed(mB));
    case (mOp)
      3'b000: begin
        p = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'b001: begin
        p = {32'b0, mA} * {32'b0, mB};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      3'b010, 3'b011: begin
        if (mB == 32'h0) begin
          e.hi = mA;
          e.lo = '1;
          e.dz = 1'b1;
        end else begin
          if (mOp == 3'b011) begin
            sa = longint'({32'b0, mA});
            sb = longint'({32'b0, mB});
          end
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      default: begin
      end
    endcase
    return e;
  endfunction

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle, then scramble the operands so
  // the unit has to rely on its latched copies.
  task automatic applyStimulus(input logic [2:0] iOp, input logic [31:0] iA,
                               input logic [31:0] iB);
    start = 1'b1;
    op    = iOp;
    a     = iA;
    b     = iB;
    step();
    start = 1'b0;
    op    = 3'($urandom_range(7, 0));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Full-latency operation: issue, track busy/hold, then score the result
  task automatic runLong(input string name, input logic [2:0] iOp,
                         input logic [31:0] iA, input logic [31:0] iB);
    exp_t        e;
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    int          cyc;
    int          busyCycles;
    bit          held;
    sbQ.push_back(model(iOp, iA, iB));
    oldHi = hi;
    oldLo = lo;
    held = 1'b1;
    busyCycles = 0;
    applyStimulus(iOp, iA, iB);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busyCycles++;
      if (hi !== oldHi || lo !== oldLo) held = 1'b0;
      step();
      cyc++;
    end
    checkCount++;
    if (cyc !== 34) $display("[TB] FAIL %s_latency: got cycle %0d required 34", name, cyc);
    else passCount++;
    checkCount++;
    if (busyCycles !== 33) $display("[TB] FAIL %s_busyCycles: got %0d required 33", name, busyCycles);
    else passCount++;
    checkCount++;
    if (held !== 1'b1) $display("[TB] FAIL %s_hiloHeld: got %0d required 1", name, held);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL %s_busyOnDone: got %b required 0", name, busy);
    else passCount++;
    e = sbQ.pop_front();
    checkCount++;
    if (hi !== e.hi) $display("[TB] FAIL %s_hi: got %h required %h", name, hi, e.hi);
    else passCount++;
    checkCount++;
    if (lo !== e.lo) $display("[TB] FAIL %s_lo: got %h required %h", name, lo, e.lo);
    else passCount++;
    checkCount++;
    if (dz !== e.dz) $display("[TB] FAIL %s_dz: got %b required %b", name, dz, e.dz);
    else passCount++;
  endtask

  // Operation that must not start the iteration nor touch HI/LO
  task automatic runNoEffect(input string name, input logic [2:0] iOp,
                             input logic [31:0] iA, input logic [31:0] iB);
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    int          activity;
    oldHi = hi;
    oldLo = lo;
    activity = 0;
    applyStimulus(iOp, iA, iB);
    repeat (40) begin
      if (busy !== 1'b0 || done !== 1'b0) activity++;
      step();
    end
    checkCount++;
    if (activity !== 0) $display("[TB] FAIL %s_activity: got %0d required 0", name, activity);
    else passCount++;
    checkCount++;
    if (hi !== oldHi) $display("[TB] FAIL %s_hi: got %h required %h", name, hi, oldHi);
    else passCount++;
    checkCount++;
    if (lo !== oldLo) $display("[TB] FAIL %s_lo: got %h required %h", name, lo, oldLo);
    else passCount++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = 3'b000;
    a = '0;
    b = '0;
    s8Start = 1'b0;
    s8Op = 3'b000;
    s8A = '0;
    s8B = '0;
    repeat (2) step();
    checkCount++;
    if (hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h required 0", hi);
    else passCount++;
    checkCount++;
    if (lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h required 0", lo);
    else passCount++;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy);
    else passCount++;
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b required 0", done);
    else passCount++;
    checkCount++;
    if (dz !== 1'b0) $display("[TB] FAIL reset_dz: got %b required 0", dz);
    else passCount++;
    checkCount++;
    if ({hi8, lo8, busy8, done8} !== 18'h0) $display("[TB] FAIL reset_w8: got %h required 0", {hi8, lo8, busy8, done8});
    else passCount++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_multu_timing();
    runLong("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    step();
    checkCount++;
    if (done !== 1'b0) $display("[TB] FAIL multu_donePulse: got %b required 0", done);
    else passCount++;
  endtask

  task automatic test_mult_signed();
    runLong("mult_neg", 3'b000, 32'hFFFFFFFD, 32'h5);
    runLong("mult_mixed", 3'b000, 32'h7FFFFFFF, 32'h80000000);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] oldLo;
    oldLo = lo;
    applyStimulus(3'b100, 32'h12345678, 32'h0);
    checkCount++;
    if (hi !== 32'h12345678) $display("[TB] FAIL mthi_hi: got %h required 12345678", hi);
    else passCount++;
    checkCount++;
    if (lo !== oldLo) $display("[TB] FAIL mthi_lo: got %h required %h", lo, oldLo);
    else passCount++;
    checkCount++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL mthi_handshake: got %b required 00", {busy, done});
    else passCount++;
    applyStimulus(3'b101, 32'hCAFEF00D, 32'h0);
    checkCount++;
    if (lo !== 32'hCAFEF00D) $display("[TB] FAIL mtlo_lo: got %h required cafef00d", lo);
    else passCount++;
    checkCount++;
    if (hi !== 32'h12345678) $display("[TB] FAIL mtlo_hi: got %h required 12345678", hi);
    else passCount++;
    runNoEffect("nop110", 3'b110, 32'h1111, 32'h2222);
    runNoEffect("nop111", 3'b111, 32'h3333, 32'h4444);
  endtask

  task automatic test_divide();
`ifdef MDU_DIV_EN
    runLong("div_neg", 3'b010, 32'hFFFFFFF9, 32'h2);
    runLong("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    runLong("divu_plain", 3'b011, 32'hFFFFFFF9, 32'h10);
`else
    runNoEffect("div_disabled", 3'b010, 32'hFFFFFFF9, 32'h2);
    runNoEffect("divu_disabled", 3'b011, 32'h80000000, 32'hFFFFFFFF);
`endif
  endtask

  task automatic test_div_by_zero();
`ifdef MDU_DIV_EN
    runLong("divu_zero", 3'b011, 32'h5, 32'h0);
    runLong("div_zero_neg", 3'b010, 32'hFFFFFF00, 32'h0);
`else
    runNoEffect("divu_zero_disabled", 3'b011, 32'h5, 32'h0);
`endif
    runLong("multu_after_dz", 3'b001, 32'h2, 32'h3);
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   cyc;
    int   doneSeen;
    sbQ.push_back(model(3'b001, 32'h7, 32'h9));
    applyStimulus(3'b001, 32'h7, 32'h9);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 5) begin
        start = 1'b1;
        op = 3'b011;
        a = 32'd100;
        b = 32'd0;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checkCount++;
    if (cyc !== 34) $display("[TB] FAIL ignore_latency: got cycle %0d required 34", cyc);
    else passCount++;
    e = sbQ.pop_front();
    checkCount++;
    if ({hi, lo, dz} !== {e.hi, e.lo, e.dz}) $display("[TB] FAIL ignore_result: got %h_%h_%b required %h_%h_%b", hi, lo, dz, e.hi, e.lo, e.dz);
    else passCount++;
    doneSeen = 0;
    repeat (40) begin
      step();
      if (done === 1'b1 || busy === 1'b1) doneSeen++;
    end
    checkCount++;
    if (doneSeen !== 0) $display("[TB] FAIL ignore_noSecondOp: got %0d required 0", doneSeen);
    else passCount++;
  endtask

  task automatic test_reset_abort();
    int doneSeen;
    applyStimulus(3'b001, 32'h7, 32'h9);
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (cyc == 5) begin
        start = 1'b1;
        op = 3'b011;
        a = 32'd100;
        b = 32'd3;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    reset = 1'b1;
    #1;
    checkCount++;
    if ({hi, lo} !== 64'h0) $display("[TB] FAIL abort_hilo: got %h required 0", {hi, lo});
    else passCount++;
    checkCount++;
    if ({busy, done} !== 2'b00) $display("[TB] FAIL abort_handshake: got %b required 00", {busy, done});
    else passCount++;
    step();
    reset = 1'b0;
    doneSeen = 0;
    repeat (40) begin
      step();
      if (done === 1'b1) doneSeen++;
    end
    checkCount++;
    if (doneSeen !== 0) $display("[TB] FAIL abort_noDone: got %0d required 0", doneSeen);
    else passCount++;
    runLong("abort_rerun", 3'b001, 32'h7, 32'h9);
  endtask

  task automatic test_back_to_back_w8();
    exp8_t e8;
    int    cyc;
    e8.hi = 8'h40;
    e8.lo = 8'h00;
    sb8Q.push_back(e8);
    s8Start = 1'b1;
    s8Op = 3'b000;
    s8A = 8'h80;
    s8B = 8'h80;
    step();
    s8Start = 1'b0;
    s8A = 8'($urandom);
    s8B = 8'($urandom);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    checkCount++;
    if (cyc !== 10) $display("[TB] FAIL w8_latency: got cycle %0d required 10", cyc);
    else passCount++;
    e8 = sb8Q.pop_front();
    checkCount++;
    if ({hi8, lo8} !== {e8.hi, e8.lo}) $display("[TB] FAIL w8_mult: got %h required %h", {hi8, lo8}, {e8.hi, e8.lo});
    else passCount++;
    checkCount++;
    if (dz8 !== 1'b0) $display("[TB] FAIL w8_dz: got %b required 0", dz8);
    else passCount++;
    e8.hi = 8'h00;
    e8.lo = 8'd15;
    sb8Q.push_back(e8);
    s8Start = 1'b1;
    s8Op = 3'b001;
    s8A = 8'd3;
    s8B = 8'd5;
    step();
    s8Start = 1'b0;
    s8A = 8'($urandom);
    s8B = 8'($urandom);
    checkCount++;
    if ({busy8, done8} !== 2'b10) $display("[TB] FAIL w8_b2bAccept: got %b required 10", {busy8, done8});
    else passCount++;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 30) begin
      step();
      cyc++;
    end
    checkCount++;
    if (cyc !== 10) $display("[TB] FAIL w8_b2bLatency: got cycle %0d required 10", cyc);
    else passCount++;
    e8 = sb8Q.pop_front();
    checkCount++;
    if ({hi8, lo8} !== {e8.hi, e8.lo}) $display("[TB] FAIL w8_b2bResult: got %h required %h", {hi8, lo8}, {e8.hi, e8.lo});
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_multu_timing();
    test_mult_signed();
    test_mthi_mtlo();
    test_divide();
    test_div_by_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back_w8();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
